// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//
// Adds or subtracts two W = K*N bit operands by walking one external K-bit
// adder across N slices, least-significant slice first, one slice per cycle.
// The running carry ripples through a register between slices.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand request channel (in_a, in_b, in_cin, in_sub)
//   adder_a/b/cin       slice operands driven to the external adder
//   adder_sum/cout      combinational result returned by the external adder
//   out_valid/out_ready result channel (out_sum, out_cout, out_ovf)
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. Once out_valid is raised it stays
// high, with out_sum/out_cout/out_ovf held stable, until that transfer. The
// ready outputs never depend combinationally on the matching valid input.
module multiword_add_sequencer #(
  parameter int K = 8,
  parameter int N = 4,
  localparam int W = K * N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic [K-1:0] adder_a,
  output logic [K-1:0] adder_b,
  output logic         adder_cin,
  input  logic [K-1:0] adder_sum,
  input  logic         adder_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       op_a_q,  op_a_d;
  logic [W-1:0]       op_b_q,  op_b_d;
  logic [W-1:0]       res_q,   res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so B is stored inverted and the
          // caller's carry-in is overridden.
          op_a_d  = in_a;
          op_b_d  = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        adder_a   = op_a_q[int'(idx_q)*K +: K];
        adder_b   = op_b_q[int'(idx_q)*K +: K];
        adder_cin = carry_q;
        res_d[int'(idx_q)*K +: K] = adder_sum;
        carry_d   = adder_cout;
        // idx stops at the last slice rather than wrapping.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers are untouched in DONE, so these stay stable under
  // backpressure without a separate output stage.
  assign out_sum  = res_q;
  assign out_cout = carry_q;
  // Signed overflow: operands of equal sign (B taken after inversion)
  // yielding a result of the other sign.
  assign out_ovf  = (op_a_q[W-1] == op_b_q[W-1]) && (res_q[W-1] != op_a_q[W-1]);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer
//
// Bench for multiword_add_sequencer (K=8, N=4). Provides a behavioural model
// of the external K-bit adder, drives directed and random requests, and
// checks results in a monitor against an expected queue filled at issue time.
module tb_multiword_add_sequencer;

  localparam int K = 8;
  localparam int N = 4;
  localparam int W = K * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic [K-1:0] adder_a, adder_b, adder_sum;
  logic         adder_cin, adder_cout;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  multiword_add_sequencer #(.K(K), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // External compressed adder: plain combinational K-bit add.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{K{1'b0}}, adder_cin};

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  int           acc_q[$];   // cycle stamp of each accepted request
  int           rise_q[$];  // cycle stamp of each out_valid rise

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: true integer arithmetic on the whole operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint ua, ub, full, sa, sb, sr;
    longint smax, smin;
    logic co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    if (sub) begin
      full = ua - ub;
      co   = (ua >= ub);        // no borrow
      sr   = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      co   = full[W];
      sr   = sa + sb + longint'(cin);
    end
    ov = (sr > smax) || (sr < smin);
    return {ov, co, full[W-1:0]};
  endfunction

  // ---------------- out_ready driver ----------------
  logic ready_mode;   // 1: random backpressure
  logic ready_val;    // value used when ready_mode == 0
  always @(posedge clk) begin
    #2;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      return;
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W+1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        if (acc_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          // Accept is stamped half a cycle before the accepting edge, so a
          // result N cycles after accept shows up as N+1 here.
          check("latency", 64'(cyc - acc_q.pop_front()), 64'(N + 1));
        end
      end
      if (out_valid && prev_stall) begin
        check("held_stable", 64'({out_ovf, out_cout, out_sum}), 64'(held));
        check("in_ready_low_in_done", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("result_without_request", 64'd1, 64'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("out_sum", 64'(out_sum), 64'(e[W-1:0]));
          check("out_cout", 64'(out_cout), 64'(e[W]));
          check("out_ovf", 64'(out_ovf), 64'(e[W+1]));
        end
      end
      prev_valid = out_valid;
      prev_stall = out_valid && !out_ready;
      held = {out_ovf, out_cout, out_sum};
    end
  end

  // ---------------- stimulus ----------------
  logic cin_seq [4];
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    ready_mode = 1'b0; ready_val = 1'b1; out_ready = 1'b1;
    cin_seq = '{1'b0, 1'b1, 1'b1, 1'b1};

    // Reset values.
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: carry ripples through every slice.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      check("adder_cin_seq", 64'(adder_cin), 64'(cin_seq[i]));
      @(posedge clk); #1;
    end
    wait_drain();

    // 2: subtraction with borrow; B slice is inverted.
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    check("sub_adder_b0", 64'(adder_b), 64'hF8);
    check("sub_adder_a0", 64'(adder_a), 64'h05);
    check("sub_adder_cin0", 64'(adder_cin), 64'd1);
    wait_drain();

    // 3: signed overflow both directions.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    wait_drain();

    // 4: backpressure; input changes after accept must not matter.
    ready_val = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      check("bp_valid_seen", 64'(out_valid), 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
      check("bp_sum", 64'(out_sum), 64'h2345_6789);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    ready_val = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    wait_drain();

    // 5: reset aborts an operation mid-RUN.
    send($urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
    check("abort_out_sum", 64'(out_sum), 64'd0);
    void'(exp_q.pop_back());
    if (acc_q.size() != 0) void'(acc_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("abort_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    wait_drain();

    // 6: back-to-back, results N+2 cycles apart.
    rise_q.delete();
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    send($urandom, $urandom, 1'b1, 1'b0);
    send($urandom, $urandom, 1'b0, 1'b1);
    wait_drain();
    if (rise_q.size() == 3) begin
      check("b2b_gap0", 64'(rise_q[1] - rise_q[0]), 64'(N + 2));
      check("b2b_gap1", 64'(rise_q[2] - rise_q[1]), 64'(N + 2));
    end else begin
      check("b2b_count", 64'(rise_q.size()), 64'd3);
    end

    // Random traffic with random backpressure.
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: b = a;
        default: ;
      endcase
      send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    ready_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
